mux_4_1_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the 4:1 mux datapath between four requesters.
- Each cycle it decides which requester owns the mux. It drives the mux select S[1:0] plus a one-hot grant back to the requesters.
- A hold counter bounds how long one owner keeps the mux while others wait, so no requester starves.
- Sits directly in front of mux_4_1: sel connects to mux_4_1.S, and requester i's data bit drives D[i].

---
 rtl/mux_4_1_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_mux_4_1_rr_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_4_1_rr_arbiter.sv
// ============================================================================
// Module      : mux_4_1_rr_arbiter
// Description : Round-robin arbiter that owns the select of a 4:1 mux. It
//               grants one of four level-sensitive requesters at a time,
//               drives the mux select and a one-hot grant, and limits how
//               long one owner may hold the mux while others are waiting.
// Ports       : clk        - rising-edge clock
//               rst        - asynchronous active-high reset
//               req[3:0]   - request vector, one bit per requester
//               gnt[3:0]   - registered one-hot grant, zero when idle
//               sel[1:0]   - registered index of current/last owner (mux S)
//               gnt_valid  - registered, high whenever gnt is non-zero
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_4_1_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       gnt_valid
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_MAX_HOLD = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_do_grant;
    logic [1:0]       w_grant_idx;
    logic [3:0]       w_others;

    // First set bit of r scanning upward from start with wrap 3->0. The scan
    // runs backwards and overwrites, so the candidate nearest start wins.
    function automatic logic [1:0] pick(input logic [1:0] start, input logic [3:0] r);
        logic [1:0] idx;
        logic [1:0] res;
        res = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                res = idx;
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            valid_q <= 1'b0;
            ptr_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        valid_d     = valid_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        w_do_grant  = 1'b0;
        w_grant_idx = ptr_q;
        // Requests other than the current owner's (gnt_q is zero when idle).
        w_others    = req & ~gnt_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    w_do_grant  = 1'b1;
                    w_grant_idx = pick(ptr_q, req);
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    if (|w_others) begin
                        // Owner released while others wait: hand over on
                        // this edge so the mux never sees an idle bubble.
                        w_do_grant  = 1'b1;
                        w_grant_idx = pick(sel_q + 2'd1, w_others);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (cnt_q < C_MAX_HOLD) begin
                    cnt_d = cnt_q + C_ONE;
                end else if (|w_others) begin
                    w_do_grant  = 1'b1;
                    w_grant_idx = pick(sel_q + 2'd1, w_others);
                end
                // Otherwise the uncontested owner keeps the grant and the
                // counter stays saturated at the limit.
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_do_grant) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << w_grant_idx;
            sel_d   = w_grant_idx;
            valid_d = 1'b1;
            cnt_d   = C_ONE;
            ptr_d   = w_grant_idx + 2'd1;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_4_1_rr_arbiter.sv
// ============================================================================
// Module      : tb_mux_4_1_rr_arbiter
// Description : Self-checking bench for mux_4_1_rr_arbiter. Two instances
//               (hold limits 4 and 1) share stimulus; an owner/queue-level
//               model is compared against both every cycle, and directed
//               literal expectations pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_4_1_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt4, gnt1;
    logic [1:0] sel4, sel1;
    logic       val4, val1;

    logic [3:0] mux_d = 4'b1010;

    int checks = 0;
    int errors = 0;

    // Model state: owner index (-1 = idle), cycles owned, rotation pointer,
    // last owner for the select output. Index 0 -> limit 4, index 1 -> limit 1.
    int m_owner [2] = '{-1, -1};
    int m_cnt   [2] = '{0, 0};
    int m_ptr   [2] = '{0, 0};
    int m_sel   [2] = '{0, 0};
    int m_limit [2] = '{4, 1};

    mux_4_1_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt4),
        .sel       (sel4),
        .gnt_valid (val4)
    );

    mux_4_1_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt1),
        .sel       (sel1),
        .gnt_valid (val1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Nearest requester at or above start, wrapping; -1 if none.
    function automatic int first_from(input int start, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_step(input int m, input logic [3:0] r);
        int o;
        int nxt;
        logic [3:0] waiting;
        o = m_owner[m];
        waiting = r;
        if (o >= 0) waiting[o] = 1'b0;
        nxt = -1;
        if (o < 0) begin
            nxt = first_from(m_ptr[m], r);
        end else if (!r[o] || m_cnt[m] >= m_limit[m]) begin
            nxt = first_from(o + 1, waiting);
            if (nxt < 0 && !r[o]) begin
                m_owner[m] = -1;
                m_cnt[m] = 0;
            end
        end else begin
            m_cnt[m] = m_cnt[m] + 1;
        end
        if (nxt >= 0) begin
            m_owner[m] = nxt;
            m_sel[m]   = nxt;
            m_cnt[m]   = 1;
            m_ptr[m]   = (nxt + 1) % 4;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                m_owner[m] = -1;
                m_cnt[m]   = 0;
                m_ptr[m]   = 0;
                m_sel[m]   = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) model_step(m, req);
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        check("gnt4 model", int'(gnt4), (m_owner[0] < 0) ? 0 : (1 << m_owner[0]));
        check("sel4 model", int'(sel4), m_sel[0]);
        check("val4 model", int'(val4), (m_owner[0] < 0) ? 0 : 1);
        check("gnt1 model", int'(gnt1), (m_owner[1] < 0) ? 0 : (1 << m_owner[1]));
        check("sel1 model", int'(sel1), m_sel[1]);
        check("val1 model", int'(val1), (m_owner[1] < 0) ? 0 : 1);
        check("gnt4 onehot", int'($countones(gnt4) <= 1), 1);
        check("gnt1 onehot", int'($countones(gnt1) <= 1), 1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [1:0] s;
        rst = 1'b1;
        tick(2);
        check("reset gnt", int'(gnt4), 0);
        check("reset sel", int'(sel4), 0);
        check("reset valid", int'(val4), 0);
        rst = 1'b0;
        tick(2);
        check("idle after reset", int'(val4), 0);

        // Single request, one-cycle latency, sel holds after release.
        req = 4'b0100;
        tick(1);
        check("single gnt", int'(gnt4), 4'b0100);
        check("single sel", int'(sel4), 2);
        check("single valid", int'(val4), 1);
        req = 4'b0000;
        tick(1);
        check("release gnt", int'(gnt4), 0);
        check("release sel held", int'(sel4), 2);

        // Asynchronous reset in the middle of a grant.
        req = 4'b0100;
        tick(1);
        check("pre-reset gnt", int'(gnt4), 4'b0100);
        #2 rst = 1'b1;
        #1;
        check("async rst gnt", int'(gnt4), 0);
        check("async rst sel", int'(sel4), 0);
        check("async rst valid", int'(val4), 0);
        tick(1);
        req = 4'b0000;
        rst = 1'b0;
        tick(2);
        check("post-reset idle", int'(gnt4), 0);

        // All four requesting: each owner keeps it for exactly four cycles.
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            check("rotate sel", int'(sel4), (c / 4) % 4);
        end
        req = 4'b0000;
        tick(2);

        // Early release hands over with no idle cycle.
        req = 4'b0110;
        tick(2);
        check("early owner", int'(gnt4), 4'b0010);
        req = 4'b0100;
        tick(1);
        check("handover gnt", int'(gnt4), 4'b0100);
        check("handover sel", int'(sel4), 2);
        check("handover valid", int'(val4), 1);
        req = 4'b0000;
        tick(2);

        // Uncontested owner saturates, then yields one edge after contention.
        req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            check("saturate gnt", int'(gnt4), 4'b0001);
        end
        req = 4'b1001;
        tick(1);
        check("sat yield gnt", int'(gnt4), 4'b1000);
        check("sat yield sel", int'(sel4), 3);
        req = 4'b0000;
        tick(2);

        // Hold limit 1: ownership alternates every cycle, mux output follows.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        req = 4'b1001;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            s = sel1;
            check("wrap sel", int'(sel1), (c % 2 == 0) ? 0 : 3);
            check("wrap mux y", int'(mux_d[s]), (c % 2 == 0) ? 0 : 1);
        end
        req = 4'b0000;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
